// File: rtl/xga_timing_pkg.sv
// Shared XGA raster timing constants for the timing generator and the pixel generators.
package xga_timing_pkg;

  localparam int unsigned CoordW    = 11;
  localparam int unsigned FrameCntW = 10;

  localparam int unsigned H_RES  = 1024;
  localparam int unsigned HFp    = 24;
  localparam int unsigned HSync  = 136;
  localparam int unsigned HBp    = 160;
  localparam int unsigned HTotal = H_RES + HFp + HSync + HBp;

  localparam int unsigned V_RES  = 768;
  localparam int unsigned VFp    = 3;
  localparam int unsigned VSync  = 6;
  localparam int unsigned VBp    = 29;
  localparam int unsigned VTotal = V_RES + VFp + VSync + VBp;

  localparam int unsigned HSyncStart = H_RES + HFp;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;
  localparam int unsigned VSyncStart = V_RES + VFp;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with enable; resets to its last value so the first enabled step wraps to 0.
module wrap_counter #(
  parameter int unsigned Modulus = 16,
  parameter int unsigned Width   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic [Width-1:0] count_next,
  output logic             carry
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;

  // carry marks the enabled step that wraps to zero
  always_comb begin
    carry   = en && (count_q == Last);
    count_d = count_q;
    if (en) begin
      count_d = (count_q == Last) ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= Last;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/xga_timing_gen.sv
// XGA raster timing generator: pixel coordinates, active qualifier, syncs, pulses, frame counter.
module xga_timing_gen
  import xga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_RES,
  parameter int unsigned H_FP      = HFp,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BP      = HBp,
  parameter int unsigned V_ACTIVE  = V_RES,
  parameter int unsigned V_FP      = VFp,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BP      = VBp,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  output logic [CoordW-1:0]    pix_x,
  output logic [CoordW-1:0]    pix_y,
  output logic                 video_active,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [FrameCntW-1:0] frame_count
);

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HAct    = 12'(H_ACTIVE);
  localparam logic [11:0] HsStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VAct    = 12'(V_ACTIVE);
  localparam logic [11:0] VsStart = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VsEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [CoordW-1:0] h_count, h_next, v_count, v_next;
  logic              h_carry, v_carry;

  wrap_counter #(.Modulus(HTot), .Width(CoordW)) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (ce),
    .count      (h_count),
    .count_next (h_next),
    .carry      (h_carry)
  );

  // h_carry is already qualified by ce
  wrap_counter #(.Modulus(VTot), .Width(CoordW)) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_carry),
    .count      (v_count),
    .count_next (v_next),
    .carry      (v_carry)
  );

  logic [11:0]          hx, vy;
  logic                 video_active_d, hsync_d, vsync_d;
  logic [FrameCntW-1:0] frame_count_d;

  logic                 video_active_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic [FrameCntW-1:0] frame_count_q;

  // Decode from the next count so registered outputs line up with the registered count
  always_comb begin
    hx             = {1'b0, h_next};
    vy             = {1'b0, v_next};
    video_active_d = (hx < HAct) && (vy < VAct);
    hsync_d        = ((hx >= HsStart) && (hx < HsEnd)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d        = ((vy >= VsStart) && (vy < VsEnd)) ? VSYNC_POL : ~VSYNC_POL;
    frame_count_d  = frame_count_q;
    if (h_carry && (vy == VsStart)) begin
      frame_count_d = frame_count_q + FrameCntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      video_active_q <= 1'b0;
      hsync_q        <= ~HSYNC_POL;
      vsync_q        <= ~VSYNC_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
    end else if (ce) begin
      video_active_q <= video_active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= h_carry;
      frame_start_q  <= v_carry;
      frame_count_q  <= frame_count_d;
    end
  end

  assign pix_x        = h_count;
  assign pix_y        = v_count;
  assign video_active = video_active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: doc/xga_timing_gen.md
# xga_timing_gen

Raster timing generator for the 1024x768 (XGA) display path. Produces the pixel coordinates, active-video qualifier, sync pulses and frame counter that the background pixel generators (Mario scene, pipes/planes) consume. It sits between the pixel clock and all per-pixel colour logic. It also provides a synchronous per-frame counter, so scroll logic no longer needs to clock on `vsync`.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (clocks)
- `H_SYNC`, 136, hsync width (clocks)
- `H_BP`, 160, horizontal back porch (clocks); H_TOTAL = 1344
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 29, vertical back porch (lines); V_TOTAL = 806
- `HSYNC_POL`, 0, asserted level of hsync (0 = active-low)
- `VSYNC_POL`, 0, asserted level of vsync

Ports:
- `clk` in 1: pixel clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `ce` in 1: pixel clock enable; all state holds when low
- `pix_x` out 11: current horizontal count, 0..H_TOTAL-1
- `pix_y` out 11: current vertical count, 0..V_TOTAL-1
- `video_active` out 1: pix_x < H_ACTIVE && pix_y < V_ACTIVE
- `hsync` out 1: horizontal sync, polarity per HSYNC_POL
- `vsync` out 1: vertical sync, polarity per VSYNC_POL
- `line_start` out 1: one-cycle pulse, pix_x == 0
- `frame_start` out 1: one-cycle pulse, pix_x == 0 && pix_y == 0
- `frame_count` out 10: frames elapsed, wraps modulo 1024

## Operation
- All outputs are registers. Every output is mutually consistent with the `pix_x`/`pix_y` it is presented with. Decodes are computed from next-count values, with no one-cycle skew.
- When `ce`=1: pix_x increments. At H_TOTAL-1 it wraps to 0 and pix_y increments. When pix_y is V_TOTAL-1 and pix_x wraps, pix_y wraps to 0.
- When `ce`=0: all outputs hold, and pulses stay at their held value. Sources drive `ce` from a clock divider, so a held pulse is an accepted artefact.
- hsync is asserted for pix_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1048,1184).
- vsync is asserted for pix_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [771,777). It changes only at pix_x == 0.
- frame_count increments by 1 on the enabled cycle where pix_y becomes 771 and pix_x becomes 0, i.e. the cycle vsync asserts. It wraps 1023 -> 0.
- Reset state is the last pixel of a frame, so the first enabled post-reset cycle is (0,0):
  - pix_x = H_TOTAL-1 (1343), pix_y = V_TOTAL-1 (805)
  - video_active = 0, hsync = vsync = deasserted (!POL)
  - line_start = frame_start = 0, frame_count = 0
- Reset dominates `ce`. Asserting reset mid-frame forces the reset state on the next edge, whatever the count.
- Parameter rule: H_TOTAL and V_TOTAL must each be ≤ 2048. Sum arithmetic is 12-bit and is compared against 11-bit counts zero-extended.

## Timing
- Latency: zero between count and decodes; all outputs change on the same `clk` edge.
- First enabled edge after reset release: pix_x=0, pix_y=0, video_active=1, line_start=1, frame_start=1.
- Line period: H_TOTAL enabled cycles (1344).
- Frame period: H_TOTAL*V_TOTAL enabled cycles (1,083,264).
- hsync is asserted for 136 enabled cycles per line.
- vsync is asserted for 6*1344 = 8064 enabled cycles per frame.
- video_active is high for 1024*768 = 786,432 enabled cycles per frame.

## Structure
- Shared package `xga_timing_pkg` holds:
  - the default timing constants
  - derived H_TOTAL/V_TOTAL and sync start/end localparams
  - the coordinate width (11)
- Pixel generators import the package for H_RES/V_RES instead of local literals.
- One sub-module, `wrap_counter` (parameterised modulus, enable, carry-out), is instantiated twice:
  - horizontal instance, enabled by `ce`
  - vertical instance, enabled by `ce` && h carry
- The decode and output registers live in the top module.

## Test plan
- Reset held 5 cycles with ce=1 -> pix_x=1343, pix_y=805, video_active=0, hsync=vsync=1, pulses 0, frame_count=0. First cycle after release -> (0,0), video_active=1, frame_start=1, line_start=1.
- Free-run one line -> hsync falls at pix_x=1048 and rises at 1184. video_active falls at pix_x=1024. line_start appears again after exactly 1344 cycles.
- Free-run two frames:
  - vsync low from (0,771) through (1343,776)
  - frame_count 0->1->2, each step at vsync assertion
  - frame_start spacing 1,083,264 cycles
- ce toggled 1-of-4 cycles -> all outputs hold during ce=0. Line length is 1344 enabled cycles (5376 clk).
- Force frame_count to 1023 via 1024 frames (or a shortened-parameter build: H_TOTAL=16, V_TOTAL=8) -> wraps to 0 at next vsync assertion.
- Reset asserted at (500,300) with ce=0 -> next edge gives the reset state. After release, the count restarts at (0,0) with frame_start=1.
